// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    PEND_HIGH,
    ST_HIGH,
    PEND_LOW
  } debounce_state_t;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronise a raw input, require STABLE_CYCLES of stability before changing the clean level,
// and emit registered rise/fall strobes. Optional glitch_cnt: INPUT_DEBOUNCER_GLITCH_CNT_EN.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  output logic a_clean,
  output logic rise,
  output logic fall
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam bit Direct = (STABLE_CYCLES == 1);

  logic            s;
  debounce_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clean_d;
  logic            rise_q, fall_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (a_raw),
    .q    (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          if (Direct) begin
            state_d = ST_HIGH;
          end else begin
            state_d = PEND_HIGH;
            cnt_d   = CntW'(1);
          end
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (Direct) begin
            state_d = ST_LOW;
          end else begin
            state_d = PEND_LOW;
            cnt_d   = CntW'(1);
          end
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Aborted pends keep the clean level, so strobes reduce to edges of the clean level.
  assign clean_d = (state_d == ST_HIGH) || (state_d == PEND_LOW);
  assign a_clean = (state_q == ST_HIGH) || (state_q == PEND_LOW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= clean_d & ~a_clean;
      fall_q  <= ~clean_d & a_clean;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_q;

  assign abort = ((state_q == PEND_HIGH) && !s) || ((state_q == PEND_LOW) && s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
